ps2_key_decoder: RTL and testbench

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/ps2_key_decoder.sv | 213 +++++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
// Receive-only PS/2 keyboard front end. It synchronizes and de-glitches the
// raw PS/2 clock and data, collects 11-bit frames on the falling edges of the
// filtered clock, and turns scan-code bytes into key events.
//   E0 sets the extended flag and F0 sets the break (release) flag. Neither
//   byte produces an event.
//   Any other good byte produces a one-cycle key_valid with {ext, byte}.
//   A bad frame or a stalled frame produces a one-cycle frame_err and clears
//   both flags.
// Optional feature: define PS2_PARITY_CHECK_EN to reject frames whose
// data+parity bits do not have odd parity. In the default build the parity
// bit is sampled and then ignored.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | bus quiet; waiting for the falling edge of a start bit
// RECV  | mid-frame; counting bits 1..10 and running the stall timeout

module ps2_key_decoder #(
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       key_valid,
   output logic [8:0] key_code,
   output logic       key_make,
   output logic       frame_err
);

   localparam int FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   // Filter terminal count: the filtered level flips on the FILTER_LEN-th
   // consecutive sample that disagrees with it.
   localparam logic [FLT_W-1:0] FLT_TC   = FLT_W'(FILTER_LEN - 1);
   // Timeout reload value: expiry happens on the TIMEOUT_CYCLES-th cycle
   // after the last falling edge.
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

   localparam logic [7:0] BYTE_EXT = 8'hE0;
   localparam logic [7:0] BYTE_BRK = 8'hF0;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RECV = 1'b1
   } state_t;

   logic             r_clk_s1;
   logic             r_clk_s2;
   logic             r_dat_s1;
   logic             r_dat_s2;
   logic             r_flt_clk;
   logic             r_flt_d;
   logic [FLT_W-1:0] r_flt_cnt;

   state_t           r_state;
   logic [3:0]       r_bit_cnt;
   logic [TMO_W-1:0] r_tmo;
   logic             r_start_bit;
   logic [7:0]       r_data;
   logic             r_ext;
   logic             r_brk;
`ifdef PS2_PARITY_CHECK_EN
   logic             r_par;
`endif

   logic             w_fall;
   logic             w_par_ok;
   logic             w_frame_ok;

   // Two-flop synchronizers; both reset to the idle-high bus level.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_clk_s1 <= 1'b1;
         r_clk_s2 <= 1'b1;
         r_dat_s1 <= 1'b1;
         r_dat_s2 <= 1'b1;
      end else begin
         r_clk_s1 <= ps2_clk;
         r_clk_s2 <= r_clk_s1;
         r_dat_s1 <= ps2_data;
         r_dat_s2 <= r_dat_s1;
      end
   end

   // Clock de-glitch filter. Any sample that agrees with the current level
   // resets the run count, so a pulse shorter than FILTER_LEN never reaches
   // the edge detector.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_flt_clk <= 1'b1;
         r_flt_d   <= 1'b1;
         r_flt_cnt <= '0;
      end else begin
         r_flt_d <= r_flt_clk;
         if (r_clk_s2 == r_flt_clk) begin
            r_flt_cnt <= '0;
         end else if (r_flt_cnt == FLT_TC) begin
            r_flt_clk <= r_clk_s2;
            r_flt_cnt <= '0;
         end else begin
            r_flt_cnt <= r_flt_cnt + FLT_W'(1);
         end
      end
   end

   assign w_fall = r_flt_d & ~r_flt_clk;

`ifdef PS2_PARITY_CHECK_EN
   // r_par already holds the XOR of the eight data bits and the parity bit.
   // Odd parity over those nine bits means the XOR is 1.
   assign w_par_ok = r_par;
`else
   assign w_par_ok = 1'b1;
`endif

   // The stop bit is the live synchronized sample in the 11th-edge cycle.
   assign w_frame_ok = ~r_start_bit & r_dat_s2 & w_par_ok;

   // Frame FSM with registered key-event and error outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_bit_cnt   <= 4'd0;
         r_tmo       <= '0;
         r_start_bit <= 1'b0;
         r_data      <= 8'h00;
         r_ext       <= 1'b0;
         r_brk       <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
         r_par       <= 1'b0;
`endif
         key_valid   <= 1'b0;
         key_code    <= 9'h000;
         key_make    <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         frame_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_tmo <= '0;
               if (w_fall) begin
                  r_state     <= ST_RECV;
                  r_bit_cnt   <= 4'd1;
                  r_tmo       <= TMO_LOAD;
                  r_start_bit <= r_dat_s2;
`ifdef PS2_PARITY_CHECK_EN
                  r_par       <= 1'b0;
`endif
               end
            end

            ST_RECV: begin
               if (w_fall) begin
                  // An edge takes priority over a timeout that expires in the
                  // same cycle and restarts the stall timer.
                  r_tmo <= TMO_LOAD;
                  if (r_bit_cnt <= 4'd8) begin
                     r_data <= {r_dat_s2, r_data[7:1]};
                  end
`ifdef PS2_PARITY_CHECK_EN
                  if (r_bit_cnt <= 4'd9) begin
                     r_par <= r_par ^ r_dat_s2;
                  end
`endif
                  if (r_bit_cnt == 4'd10) begin
                     r_state   <= ST_IDLE;
                     r_bit_cnt <= 4'd0;
                     r_tmo     <= '0;
                     if (!w_frame_ok) begin
                        frame_err <= 1'b1;
                        r_ext     <= 1'b0;
                        r_brk     <= 1'b0;
                     end else if (r_data == BYTE_EXT) begin
                        r_ext <= 1'b1;
                     end else if (r_data == BYTE_BRK) begin
                        r_brk <= 1'b1;
                     end else begin
                        key_valid <= 1'b1;
                        key_code  <= {r_ext, r_data};
                        key_make  <= ~r_brk;
                        r_ext     <= 1'b0;
                        r_brk     <= 1'b0;
                     end
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                  end
               end else if (r_tmo == '0) begin
                  // The keyboard stalled mid-frame, so drop the partial frame.
                  r_state   <= ST_IDLE;
                  r_bit_cnt <= 4'd0;
                  frame_err <= 1'b1;
                  r_ext     <= 1'b0;
                  r_brk     <= 1'b0;
               end else begin
                  r_tmo <= r_tmo - TMO_W'(1);
               end
            end

            default: begin
               r_state   <= ST_IDLE;
               r_bit_cnt <= 4'd0;
               r_tmo     <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder. Expected key events and errors are
// queued before each frame is sent. A monitor pops and compares an entry
// whenever the DUT raises key_valid or frame_err.
module tb_ps2_key_decoder;

   localparam int FL   = 4;
   localparam int TO   = 400;
   localparam int HALF = 20;

   logic       clk = 1'b0;
   logic       rst;
   logic       ps2_clk;
   logic       ps2_data;
   logic       key_valid;
   logic [8:0] key_code;
   logic       key_make;
   logic       frame_err;

   ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .key_valid (key_valid),
      .key_code  (key_code),
      .key_make  (key_make),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       err;
      logic [8:0] code;
      logic       make;
   } exp_t;

   exp_t       q[$];
   int         checks   = 0;
   int         failures = 0;
   logic [8:0] last_code = 9'h000;
   logic       last_make = 1'b0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic push_key(input logic [8:0] code, input logic make);
      exp_t e;
      e.err  = 1'b0;
      e.code = code;
      e.make = make;
      q.push_back(e);
   endtask

   task automatic push_err();
      exp_t e;
      e.err  = 1'b1;
      e.code = 9'h000;
      e.make = 1'b0;
      q.push_back(e);
   endtask

   // Sends the first nbits of an 11-bit frame. Data changes while the PS/2
   // clock is high, and a glitch adds a one-cycle pulse to each phase.
   task automatic send_frame(input logic [7:0] d, input bit flip_par, input bit bad_start,
                             input bit bad_stop, input bit glitch, input int nbits);
      logic [10:0] f;
      f = {~bad_stop, (~^d) ^ flip_par, d, bad_start};
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         ps2_data = f[i];
         repeat (HALF/2) @(negedge clk);
         if (glitch) begin
            ps2_clk = 1'b0;
            @(negedge clk);
            ps2_clk = 1'b1;
         end
         repeat (HALF/2) @(negedge clk);
         ps2_clk = 1'b0;
         repeat (HALF/2) @(negedge clk);
         if (glitch) begin
            ps2_clk = 1'b1;
            @(negedge clk);
            ps2_clk = 1'b0;
         end
         repeat (HALF/2) @(negedge clk);
         ps2_clk = 1'b1;
      end
      repeat (HALF) @(negedge clk);
   endtask

   task automatic good(input logic [7:0] d);
      send_frame(d, 1'b0, 1'b0, 1'b0, 1'b0, 11);
   endtask

   task automatic check_hold(input string name);
      check({name, "_code_hold"}, {7'd0, key_code}, {7'd0, last_code});
      check({name, "_make_hold"}, {15'd0, key_make}, {15'd0, last_make});
   endtask

   initial begin
      rst      = 1'b0;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;

      fork
         forever begin
            exp_t e;
            @(negedge clk);
            if (rst && (key_valid || frame_err)) begin
               checks++;
               if (key_valid && frame_err) begin
                  failures++;
                  $display("FAIL pulse_overlap actual=valid1_err1 required=one_only");
               end else if (q.size() == 0) begin
                  failures++;
                  $display("FAIL unexpected_pulse actual=valid%0d_err%0d code=%h required=none",
                           key_valid, frame_err, key_code);
               end else begin
                  e = q.pop_front();
                  if (e.err) begin
                     if (!frame_err) begin
                        failures++;
                        $display("FAIL expect_err actual=key_valid code=%h required=frame_err", key_code);
                     end
                  end else if (!key_valid || key_code !== e.code || key_make !== e.make) begin
                     failures++;
                     $display("FAIL key_event actual=valid%0d code=%h make=%0d required=code=%h make=%0d",
                              key_valid, key_code, key_make, e.code, e.make);
                  end else begin
                     last_code = e.code;
                     last_make = e.make;
                  end
               end
            end
         end
      join_none

      repeat (5) @(negedge clk);
      check("rst_valid", {15'd0, key_valid}, 16'h0000);
      check("rst_err",   {15'd0, frame_err}, 16'h0000);
      check("rst_code",  {7'd0, key_code},   16'h0000);
      check("rst_make",  {15'd0, key_make},  16'h0000);
      rst = 1'b1;
      repeat (FL + 10) @(negedge clk);

      // Plain make code
      push_key(9'h01C, 1'b1);
      good(8'h1C);
      check_hold("make_1c");

      // Break code
      push_key(9'h01C, 1'b0);
      good(8'hF0);
      good(8'h1C);
      check_hold("break_1c");

      // Extended break code
      push_key(9'h175, 1'b0);
      good(8'hE0);
      good(8'hF0);
      good(8'h75);
      check_hold("ext_break_75");

      // Repeated prefixes have no extra effect
      push_key(9'h11C, 1'b1);
      good(8'hE0);
      good(8'hE0);
      good(8'h1C);
      push_key(9'h074, 1'b0);
      good(8'hF0);
      good(8'hF0);
      good(8'h74);
      check_hold("dup_prefix");

      // Parity bit flipped
`ifdef PS2_PARITY_CHECK_EN
      push_err();
`else
      push_key(9'h01C, 1'b1);
`endif
      send_frame(8'h1C, 1'b1, 1'b0, 1'b0, 1'b0, 11);
      check_hold("bad_parity");

      // Stop bit and start bit errors; an error clears a pending E0
      push_err();
      send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 11);
      push_err();
      good(8'hE0);
      send_frame(8'h33, 1'b0, 1'b1, 1'b0, 1'b0, 11);
      push_key(9'h01C, 1'b1);
      good(8'h1C);
      check_hold("err_clears_ext");

      // Stall after five bits, then a good frame
      push_err();
      send_frame(8'h29, 1'b0, 1'b0, 1'b0, 1'b0, 5);
      repeat (TO + 50) @(negedge clk);
      push_key(9'h029, 1'b1);
      good(8'h29);
      check_hold("timeout_29");

      // Glitches shorter than the filter length
      push_key(9'h01C, 1'b1);
      send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 11);
      check_hold("glitch_1c");

      // Reset in the middle of a frame, after an E0 prefix
      good(8'hE0);
      send_frame(8'h75, 1'b0, 1'b0, 1'b0, 1'b0, 5);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_rst_code",  {7'd0, key_code},  16'h0000);
      check("mid_rst_valid", {15'd0, key_valid}, 16'h0000);
      last_code = 9'h000;
      last_make = 1'b0;
      rst = 1'b1;
      repeat (FL + 10) @(negedge clk);
      push_key(9'h075, 1'b1);
      good(8'h75);
      check_hold("post_rst_75");

      repeat (50) @(negedge clk);
      check("queue_drained", 16'(q.size()), 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
